rx_ctrl_fsm: RTL and testbench
==============================

// Module: rx_ctrl_fsm
// PURPOSE
//  Receive-control state machine for the UART receiver. Sequences the bit timer
//  (enable_timer / packet_done), the stop-bit checker (sbc_clear / sbc_enable /
//  framing_error) and the RX data buffer (load_buffer) for one serial frame.
//  Sits between the start-bit detector and the timer, SR and stop-bit checker.
//  A watchdog aborts a frame whose packet_done never arrives.
// PARAMETERS
//  TO_BITS      8    width of watchdog counter
//  TIMEOUT      120  max cycles in RECV before abort (1..2**TO_BITS-1)
//  ERR_CNT_BITS 4    width of error counter (used only with RX_ERR_CNT_EN)
// PORTS
//  clk                input  1             system clock, rising edge
//  n_rst              input  1             async active-low reset
//  start_bit_detected input  1             1-cycle pulse, start bit seen
//  packet_done        input  1             timer: last bit of frame sampled
//  framing_error      input  1             checker: stop bit was 0 (registered)
//  enable_timer       output 1             run bit timer
//  sbc_clear          output 1             clear stop-bit checker/error flag
//  sbc_enable         output 1             checker samples stop bit this cycle
//  load_buffer        output 1             1-cycle pulse, commit byte to buffer
//  rx_abort           output 1             1-cycle pulse, watchdog abort
// BEHAVIOUR
//  - Clock: clk. Reset: n_rst, asynchronous, active-low. Reset: state=IDLE, watchdog=0,
//    all outputs 0.
//  - Moore outputs, decoded from state register only; no input->output comb paths.
//  - States / transitions (one per clk):
//    IDLE     : outs 0. start_bit_detected -> START, else stay.
//    START    : sbc_clear=1. -> RECV unconditionally (1 cycle).
//    RECV     : enable_timer=1; watchdog increments each cycle from 0.
//               packet_done -> STOP_CHK (priority over timeout);
//               else watchdog==TIMEOUT-1 -> ABORT.
//    STOP_CHK : sbc_enable=1, enable_timer=0 (drops timer, clears it). -> ERR_WAIT.
//    ERR_WAIT : outs 0. framing_error -> IDLE (byte discarded); else -> LOAD.
//    LOAD     : load_buffer=1. -> IDLE.
//    ABORT    : rx_abort=1. -> IDLE.
//  - Watchdog cleared to 0 on every entry to RECV; holds 0 outside RECV; never wraps.
//  - start_bit_detected ignored in every state except IDLE (no queuing).
//  - packet_done ignored outside RECV.
//  - Frame latency: start pulse at cycle 0 -> RECV at 2; packet_done seen at N
//    -> load_buffer high at N+3, IDLE at N+4.
//  - Exactly one of sbc_clear/sbc_enable/load_buffer/rx_abort high per cycle, max.
//  - n_rst low mid-frame: immediate IDLE, outputs 0, no load_buffer/rx_abort pulse.
//  - Illegal state encodings -> IDLE next cycle.
// CONFIGURATION
//  RX_ERR_CNT_EN defined: adds ports err_cnt_clr (in,1) and err_count
//   (out,ERR_CNT_BITS). err_count += 1 on ERR_WAIT with framing_error and on ABORT;
//   saturates at all-ones; err_cnt_clr synchronous clear, wins over increment;
//   reset 0.
//  RX_ERR_CNT_EN undefined: ports and counter absent; all other behaviour identical.
// TESTING
//  - Reset: n_rst=0 -> all outputs 0, state IDLE; release, no stimulus -> stays idle.
//  - Good frame: start pulse @0, packet_done @40 -> sbc_clear @1, enable_timer 2..40,
//    sbc_enable @41, framing_error=0 -> load_buffer @43, IDLE @44.
//  - Bad stop bit: same as above with framing_error=1 @42 -> no load_buffer,
//    IDLE @43; err_count 0->1 (RX_ERR_CNT_EN).
//  - Timeout: start pulse, no packet_done, TIMEOUT=120 -> rx_abort one cycle after
//    120 RECV cycles; packet_done on the final RECV cycle -> STOP_CHK, no abort.
//  - Ignored events: start pulses during RECV/LOAD and packet_done in IDLE
//    -> no state change.
//  - Reset mid-RECV, then err counter: n_rst low @20 -> outputs 0 at once;
//    16 aborts with ERR_CNT_BITS=4 -> err_count holds 15; err_cnt_clr -> 0.

Source files
------------

// File: rtl/rx_ctrl_fsm_if.sv
// Handshake bundle between the UART RX control FSM and its neighbours
// (start-bit detector, bit timer, stop-bit checker, RX buffer). RX_ERR_CNT_EN adds the error-counter pair.
interface rx_ctrl_fsm_if #(
  parameter int ERR_CNT_BITS = 4
);
  logic start_bit_detected;
  logic packet_done;
  logic framing_error;
  logic enable_timer;
  logic sbc_clear;
  logic sbc_enable;
  logic load_buffer;
  logic rx_abort;
`ifdef RX_ERR_CNT_EN
  logic                    err_cnt_clr;
  logic [ERR_CNT_BITS-1:0] err_count;

  modport master (
    output start_bit_detected, packet_done, framing_error, err_cnt_clr,
    input  enable_timer, sbc_clear, sbc_enable, load_buffer, rx_abort, err_count
  );
  modport slave (
    input  start_bit_detected, packet_done, framing_error, err_cnt_clr,
    output enable_timer, sbc_clear, sbc_enable, load_buffer, rx_abort, err_count
  );
`else
  modport master (
    output start_bit_detected, packet_done, framing_error,
    input  enable_timer, sbc_clear, sbc_enable, load_buffer, rx_abort
  );
  modport slave (
    input  start_bit_detected, packet_done, framing_error,
    output enable_timer, sbc_clear, sbc_enable, load_buffer, rx_abort
  );
`endif
endinterface

// File: rtl/rx_ctrl_fsm.sv
// UART receive-control FSM: sequences bit timer, stop-bit checker and RX buffer per frame,
// with a RECV watchdog. Define RX_ERR_CNT_EN to add the saturating error counter.
module rx_ctrl_fsm #(
  parameter int TO_BITS      = 8,
  parameter int TIMEOUT      = 120,
  parameter int ERR_CNT_BITS = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  rx_ctrl_fsm_if.slave bus
);

  if (TIMEOUT < 1 || TIMEOUT > (2**TO_BITS) - 1 || ERR_CNT_BITS < 1) begin : g_bad_param
    $error("rx_ctrl_fsm: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    RECV     = 3'd2,
    STOP_CHK = 3'd3,
    ERR_WAIT = 3'd4,
    LOAD     = 3'd5,
    ABORT    = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [TO_BITS-1:0] wd_q, wd_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    wd_d    = '0;
    unique case (state_q)
      IDLE:     state_d = bus.start_bit_detected ? START : IDLE;
      START:    state_d = RECV;
      RECV: begin
        // packet_done beats the watchdog when both land on the last RECV cycle
        if (bus.packet_done)                        state_d = STOP_CHK;
        else if (wd_q == TO_BITS'(TIMEOUT - 1))     state_d = ABORT;
        else begin
          state_d = RECV;
          wd_d    = wd_q + 1'b1;
        end
      end
      STOP_CHK: state_d = ERR_WAIT;
      ERR_WAIT: state_d = bus.framing_error ? IDLE : LOAD;
      LOAD:     state_d = IDLE;
      ABORT:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Moore decode: outputs depend on state_q only
  always_comb begin
    bus.enable_timer = (state_q == RECV);
    bus.sbc_clear    = (state_q == START);
    bus.sbc_enable   = (state_q == STOP_CHK);
    bus.load_buffer  = (state_q == LOAD);
    bus.rx_abort     = (state_q == ABORT);
  end

`ifdef RX_ERR_CNT_EN
  logic [ERR_CNT_BITS-1:0] err_q, err_d;
  logic                    err_evt;

  assign err_evt = ((state_q == ERR_WAIT) && bus.framing_error) || (state_q == ABORT);

  always_comb begin
    err_d = err_q;
    if (bus.err_cnt_clr)         err_d = '0;
    else if (err_evt && !(&err_q)) err_d = err_q + ERR_CNT_BITS'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) err_q <= '0;
    else        err_q <= err_d;
  end

  assign bus.err_count = err_q;
`endif

endmodule

// File: tb/tb_rx_ctrl_fsm.sv
// Directed bench for rx_ctrl_fsm: frame timing, bad stop bit, watchdog, ignored events,
// mid-frame reset and (with RX_ERR_CNT_EN) the saturating error counter.
module tb_rx_ctrl_fsm;
  localparam int TO  = 120;
  localparam int ECB = 4;

  logic clk = 1'b0;
  logic n_rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_err = 0;

  always #5 clk = ~clk;

  rx_ctrl_fsm_if #(.ERR_CNT_BITS(ECB)) bus ();

  rx_ctrl_fsm #(.TO_BITS(8), .TIMEOUT(TO), .ERR_CNT_BITS(ECB)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  // {enable_timer, sbc_clear, sbc_enable, load_buffer, rx_abort}
  function automatic logic [4:0] outs();
    return {bus.enable_timer, bus.sbc_clear, bus.sbc_enable, bus.load_buffer, bus.rx_abort};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.start_bit_detected = 1'b0;
    bus.packet_done        = 1'b0;
    bus.framing_error      = 1'b0;
`ifdef RX_ERR_CNT_EN
    bus.err_cnt_clr        = 1'b0;
`endif
  endtask

  task automatic check_err(input string nm);
`ifdef RX_ERR_CNT_EN
    n_cmp++;
    if (bus.err_count !== ECB'(exp_err)) begin
      n_bad++;
      $display("FAIL %s err_count got %0d want %0d", nm, bus.err_count, exp_err);
    end
`endif
  endtask

  // One frame from the start pulse at c=0. pd_at<0 (or beyond RECV) means no packet_done.
  task automatic run_frame(input string nm, input int pd_at, input bit fe,
                           input bit noise, input bit clr_on_err);
    bit         pd_ok, err_evt;
    int         end_recv, err_cyc, last;
    logic [4:0] exp;
    pd_ok    = (pd_at >= 2) && (pd_at <= TO + 1);
    end_recv = pd_ok ? pd_at : TO + 1;
    err_cyc  = pd_ok ? end_recv + 2 : end_recv + 1;
    last     = end_recv + 6;
    err_evt  = !pd_ok || fe;
    for (int c = 0; c <= last; c++) begin
      bus.start_bit_detected = (c == 0) ||
        (noise && (c == 1 || c == 10 || c == end_recv + 3));
      bus.packet_done   = (c == pd_at) || (noise && c == end_recv + 1);
      bus.framing_error = fe && (c == end_recv + 2);
`ifdef RX_ERR_CNT_EN
      bus.err_cnt_clr   = clr_on_err && (c == err_cyc);
`endif
      exp = 5'b0;
      if (c == 1) exp = 5'b01000;
      else if (c >= 2 && c <= end_recv) exp = 5'b10000;
      else if (pd_ok && c == end_recv + 1) exp = 5'b00100;
      else if (pd_ok && !fe && c == end_recv + 3) exp = 5'b00010;
      else if (!pd_ok && c == end_recv + 1) exp = 5'b00001;
      n_cmp++;
      if (outs() !== exp) begin
        n_bad++;
        $display("FAIL %s c=%0d outs got %b want %b", nm, c, outs(), exp);
      end
      if (c == err_cyc + 1) begin
        if (clr_on_err) exp_err = 0;
        else if (err_evt && exp_err < (2**ECB) - 1) exp_err++;
        check_err(nm);
      end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_reset();
    logic [4:0] o;
    drive_idle();
    n_rst = 1'b0;
    #12;
    n_cmp++;
    o = outs();
    if (o !== 5'b0) begin
      n_bad++;
      $display("FAIL reset outs got %b want 00000", o);
    end
    exp_err = 0;
    check_err("reset");
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (outs() !== 5'b0) begin
        n_bad++;
        $display("FAIL reset_idle c=%0d outs got %b want 00000", c, outs());
      end
      tick();
    end
  endtask

  task automatic test_good_frame();
    run_frame("good_frame", 40, 1'b0, 1'b0, 1'b0);
    run_frame("short_frame", 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_bad_stop();
    run_frame("bad_stop", 40, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_frame("timeout", -1, 1'b0, 1'b0, 1'b0);
    run_frame("pd_last_recv", TO + 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored();
    bus.packet_done = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (outs() !== 5'b0) begin
        n_bad++;
        $display("FAIL pd_in_idle c=%0d outs got %b want 00000", c, outs());
      end
    end
    drive_idle();
    run_frame("ignored_events", 30, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_recv();
    for (int c = 0; c < 20; c++) begin
      bus.start_bit_detected = (c == 0);
      tick();
    end
    drive_idle();
    n_cmp++;
    if (outs() !== 5'b10000) begin
      n_bad++;
      $display("FAIL mid_recv_pre outs got %b want 10000", outs());
    end
    #2 n_rst = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== 5'b0) begin
      n_bad++;
      $display("FAIL mid_recv_rst outs got %b want 00000", outs());
    end
    exp_err = 0;
    check_err("mid_recv_rst");
    tick();
    tick();
    n_rst = 1'b1;
    bus.packet_done = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (outs() !== 5'b0) begin
        n_bad++;
        $display("FAIL post_rst_idle c=%0d outs got %b want 00000", c, outs());
      end
    end
    drive_idle();
    run_frame("post_rst_frame", 25, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_err_counter();
`ifdef RX_ERR_CNT_EN
    for (int i = 0; i < 16; i++) run_frame("err_sat", -1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.err_count !== 4'd15) begin
      n_bad++;
      $display("FAIL err_sat_15 err_count got %0d want 15", bus.err_count);
    end
    run_frame("err_sat_hold", 40, 1'b1, 1'b0, 1'b0);
    run_frame("err_clr_wins", -1, 1'b0, 1'b0, 1'b1);
    run_frame("err_after_clr", 40, 1'b1, 1'b0, 1'b0);
    bus.err_cnt_clr = 1'b1;
    tick();
    bus.err_cnt_clr = 1'b0;
    exp_err = 0;
    check_err("err_clr");
`endif
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_stop();
    test_timeout();
    test_ignored();
    test_reset_mid_recv();
    test_err_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
